// File: rtl/wb_commit_tracer.sv
// Commit-trace unit: logs WB register writes into a FWFT FIFO with cycle stamps and detects end of program.
// Optional macro COMMIT_PC_EN adds WB_PC / OUT_PC and a PC field in each record.
module wb_commit_tracer #(
  parameter int DEPTH      = 16,
  parameter int IDLE_LIMIT = 8
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        WB_VALID,
  input  logic        WB_REGWRITE,
  input  logic [4:0]  WB_ADDR,
  input  logic [31:0] WB_DATA,
  input  logic        WB_HALT,
`ifdef COMMIT_PC_EN
  input  logic [31:0] WB_PC,
  output logic [31:0] OUT_PC,
`endif
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_CYCLE,
  output logic [4:0]  OUT_ADDR,
  output logic [31:0] OUT_DATA,
  output logic [31:0] CYCLE,
  output logic [31:0] RETIRED,
  output logic        OVERFLOW,
  output logic        DONE
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(IDLE_LIMIT + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q;
  logic [AW:0]     wptr_q, rptr_q, wptr_d, rptr_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [31:0]     cycle_q, retired_q;
  logic            overflow_q, done_q;

  logic [31:0]     cyc_mem  [DEPTH];
  logic [4:0]      addr_mem [DEPTH];
  logic [31:0]     data_mem [DEPTH];
`ifdef COMMIT_PC_EN
  logic [31:0]     pc_mem   [DEPTH];
`endif

  logic empty, full, push, pop, wr_en;

  always_comb begin
    empty  = (wptr_q == rptr_q);
    full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    push   = (state_q == S_RUN) && WB_VALID && WB_REGWRITE && (WB_ADDR != 5'd0);
    pop    = !empty && OUT_READY;
    // A full FIFO still accepts a push when the head leaves in the same edge.
    wr_en  = push && (!full || pop);
    rptr_d = rptr_q + (AW+1)'(pop);
    wptr_d = wptr_q + (AW+1)'(wr_en);
    idle_d = idle_q;
    if (state_q == S_RUN) begin
      if (WB_VALID)
        idle_d = '0;
      else if (idle_q != IW'(IDLE_LIMIT))
        idle_d = idle_q + IW'(1);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (wr_en) begin
      cyc_mem[wptr_q[AW-1:0]]  <= cycle_q;
      addr_mem[wptr_q[AW-1:0]] <= WB_ADDR;
      data_mem[wptr_q[AW-1:0]] <= WB_DATA;
`ifdef COMMIT_PC_EN
      pc_mem[wptr_q[AW-1:0]]   <= WB_PC;
`endif
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_RUN;
      wptr_q     <= '0;
      rptr_q     <= '0;
      idle_q     <= '0;
      cycle_q    <= '0;
      retired_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      idle_q <= idle_d;
      if (push && full && !pop)
        overflow_q <= 1'b1;
      if (state_q != S_DONE)
        cycle_q <= cycle_q + 32'd1;
      case (state_q)
        S_RUN: begin
          if (WB_VALID)
            retired_q <= retired_q + 32'd1;
          if ((WB_VALID && WB_HALT) || (idle_d == IW'(IDLE_LIMIT)))
            state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // Empty after this edge's pop: nothing left to drain.
          if (rptr_d == wptr_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: done_q <= 1'b1;
      endcase
    end
  end

  always_comb begin
    OUT_VALID = !empty;
    OUT_CYCLE = empty ? 32'd0 : cyc_mem[rptr_q[AW-1:0]];
    OUT_ADDR  = empty ? 5'd0  : addr_mem[rptr_q[AW-1:0]];
    OUT_DATA  = empty ? 32'd0 : data_mem[rptr_q[AW-1:0]];
`ifdef COMMIT_PC_EN
    OUT_PC    = empty ? 32'd0 : pc_mem[rptr_q[AW-1:0]];
`endif
  end

  assign CYCLE    = cycle_q;
  assign RETIRED  = retired_q;
  assign OVERFLOW = overflow_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_wb_commit_tracer.sv
// Self-checking bench for wb_commit_tracer: vector table, directed corner sequences, random run vs queue model.
module tb_wb_commit_tracer;
  localparam int DEPTH      = 16;
  localparam int IDLE_LIMIT = 8;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        WB_VALID = 1'b0, WB_REGWRITE = 1'b0, WB_HALT = 1'b0, OUT_READY = 1'b0;
  logic [4:0]  WB_ADDR = '0;
  logic [31:0] WB_DATA = '0;
  logic        OUT_VALID, OVERFLOW, DONE;
  logic [31:0] OUT_CYCLE, OUT_DATA, CYCLE, RETIRED;
  logic [4:0]  OUT_ADDR;
`ifdef COMMIT_PC_EN
  logic [31:0] WB_PC = '0;
  logic [31:0] OUT_PC;
`endif

  always #5 CLOCK = ~CLOCK;

  wb_commit_tracer #(.DEPTH(DEPTH), .IDLE_LIMIT(IDLE_LIMIT)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .WB_VALID(WB_VALID), .WB_REGWRITE(WB_REGWRITE), .WB_ADDR(WB_ADDR),
    .WB_DATA(WB_DATA), .WB_HALT(WB_HALT),
`ifdef COMMIT_PC_EN
    .WB_PC(WB_PC), .OUT_PC(OUT_PC),
`endif
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_CYCLE(OUT_CYCLE),
    .OUT_ADDR(OUT_ADDR), .OUT_DATA(OUT_DATA), .CYCLE(CYCLE), .RETIRED(RETIRED),
    .OVERFLOW(OVERFLOW), .DONE(DONE)
  );

  int n_tests = 0;
  int n_fail  = 0;
  string phase = "init";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, name, act, exp);
    end
  endtask

  // Reference model: trace as a queue of records, program state as 0=run 1=drain 2=done.
  typedef struct packed {
    logic [31:0] c;
    logic [4:0]  a;
    logic [31:0] d;
  } rec_t;

  rec_t        mq[$];
  int          m_st;
  int          m_idle;
  logic [31:0] m_cyc, m_ret;
  bit          m_ovf;

  function automatic void model_reset();
    mq.delete();
    m_st = 0; m_idle = 0; m_cyc = 0; m_ret = 0; m_ovf = 0;
  endfunction

  function automatic void model_edge(input bit v, input bit rw, input logic [4:0] a,
                                     input logic [31:0] d, input bit h, input bit r);
    bit run, pop, push;
    int nxt;
    run  = (m_st == 0);
    pop  = (mq.size() > 0) && r;
    push = run && v && rw && (a != 5'd0);
    nxt  = m_st;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back('{c: m_cyc, a: a, d: d});
      else m_ovf = 1;
    end
    if (run) begin
      if (v) m_ret = m_ret + 1;
      m_idle = v ? 0 : ((m_idle < IDLE_LIMIT) ? m_idle + 1 : m_idle);
      if ((v && h) || (m_idle == IDLE_LIMIT)) nxt = 1;
    end else if (m_st == 1 && mq.size() == 0) begin
      nxt = 2;
    end
    if (m_st != 2) m_cyc = m_cyc + 1;
    m_st = nxt;
  endfunction

  task automatic model_check();
    rec_t hd;
    hd = (mq.size() > 0) ? mq[0] : '0;
    chk("out_valid", OUT_VALID, (mq.size() > 0));
    chk("out_cycle", OUT_CYCLE, hd.c);
    chk("out_addr",  OUT_ADDR,  hd.a);
    chk("out_data",  OUT_DATA,  hd.d);
    chk("cycle",     CYCLE,     m_cyc);
    chk("retired",   RETIRED,   m_ret);
    chk("overflow",  OVERFLOW,  m_ovf);
    chk("done",      DONE,      (m_st == 2));
  endtask

  bit          popped;
  logic [4:0]  pop_a;
  logic [31:0] pop_d, pop_c;

  task automatic step(input bit v, input bit rw, input logic [4:0] a,
                      input logic [31:0] d, input bit h, input bit r);
    WB_VALID = v; WB_REGWRITE = rw; WB_ADDR = a; WB_DATA = d; WB_HALT = h; OUT_READY = r;
    #1;
    popped = OUT_VALID && r;
    pop_a = OUT_ADDR; pop_d = OUT_DATA; pop_c = OUT_CYCLE;
    @(posedge CLOCK);
    model_edge(v, rw, a, d, h, r);
    #1;
    model_check();
  endtask

  task automatic do_reset();
    WB_VALID = 0; WB_REGWRITE = 0; WB_ADDR = 0; WB_DATA = 0; WB_HALT = 0; OUT_READY = 0;
    RESET_N = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_cycle", OUT_CYCLE, 0);
    chk("rst_out_addr",  OUT_ADDR,  0);
    chk("rst_out_data",  OUT_DATA,  0);
    chk("rst_cycle",     CYCLE,     0);
    chk("rst_retired",   RETIRED,   0);
    chk("rst_overflow",  OVERFLOW,  0);
    chk("rst_done",      DONE,      0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
  endtask

  typedef struct {
    bit          v, rw;
    logic [4:0]  a;
    logic [31:0] d;
    bit          r, ev;
    logic [31:0] ec;
    logic [4:0]  ea;
    logic [31:0] ed, eret;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   npop, cnt;
    logic [31:0] last_d, frozen;
    logic [4:0]  last_a;

    // Three writes: $8<-5 at cycle 2, $9<-7 at cycle 3, $0<-1 at cycle 4.
    tbl[0] = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, 32'd0};
    tbl[1] = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, 32'd0};
    tbl[2] = '{1'b1, 1'b1, 5'd8, 32'd5, 1'b1, 1'b1, 32'd2, 5'd8, 32'd5, 32'd1};
    tbl[3] = '{1'b1, 1'b1, 5'd9, 32'd7, 1'b1, 1'b1, 32'd3, 5'd9, 32'd7, 32'd2};
    tbl[4] = '{1'b1, 1'b1, 5'd0, 32'd1, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, 32'd3};

    phase = "table";
    do_reset();
    npop = 0;
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].v, tbl[i].rw, tbl[i].a, tbl[i].d, 1'b0, tbl[i].r);
      if (popped) npop++;
      chk("t_valid",   OUT_VALID, tbl[i].ev);
      chk("t_cycle",   OUT_CYCLE, tbl[i].ec);
      chk("t_addr",    OUT_ADDR,  tbl[i].ea);
      chk("t_data",    OUT_DATA,  tbl[i].ed);
      chk("t_retired", RETIRED,   tbl[i].eret);
      chk("t_clock",   CYCLE,     32'(i + 1));
    end
    chk("t_records", npop, 2);

    phase = "overflow";
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      step(1'b1, 1'b1, 5'(i), 32'(100 + i), 1'b0, 1'b0);
      if (i == 16) chk("ovf_at16", OVERFLOW, 0);
      if (i == 17) chk("ovf_at17", OVERFLOW, 1);
    end
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      chk("ovf_popped", popped, 1);
      chk("ovf_pop_addr", pop_a, 32'(k));
      chk("ovf_pop_data", pop_d, 32'(100 + k));
    end
    chk("ovf_empty", OUT_VALID, 0);
    chk("ovf_sticky", OVERFLOW, 1);

    phase = "fullpushpop";
    do_reset();
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b1, 5'(i), 32'(200 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd20, 32'd999, 1'b0, 1'b1);
    chk("fpp_overflow", OVERFLOW, 0);
    chk("fpp_first_pop", pop_d, 201);
    cnt = 0; last_d = 0;
    for (int k = 0; k < 24 && OUT_VALID; k++) begin
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      if (popped) begin cnt++; last_d = pop_d; end
    end
    chk("fpp_occupancy", cnt, 16);
    chk("fpp_last", last_d, 999);

    phase = "halt";
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 5'(10 + i), 32'(300 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd2, 32'd9, 1'b1, 1'b1);
    cnt = popped ? 1 : 0;
    last_a = 0; last_d = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 5'd7, 32'hDEAD, 1'b0, 1'b1);
      if (popped) begin cnt++; last_a = pop_a; last_d = pop_d; end
    end
    chk("halt_records", cnt, 5);
    chk("halt_last_addr", last_a, 2);
    chk("halt_last_data", last_d, 9);
    chk("halt_done", DONE, 1);
    chk("halt_retired", RETIRED, 5);
    frozen = CYCLE;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("halt_cycle_frozen", CYCLE, frozen);

    phase = "idle";
    do_reset();
    for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd3, 32'd33, 1'b0, 1'b0);
    chk("idle7_still_run", OUT_VALID, 1);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      if (k == 8) chk("idle8_not_done_yet", DONE, 0);
    end
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("idle9_done", DONE, 1);

    phase = "midreset";
    do_reset();
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 5'(i), 32'(400 + i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("mr_pending", OUT_VALID, 1);
    chk("mr_not_done", DONE, 0);
    #2;
    do_reset();
    chk("mr_cycle_zero", CYCLE, 0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("mr_cycle_restart", CYCLE, 1);

    for (int run = 0; run < 4; run++) begin
      phase = $sformatf("random%0d", run);
      do_reset();
      for (int c = 0; c < 400; c++) begin
        bit v, rw, h, r;
        logic [4:0] a;
        v  = (run == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
        rw = ($urandom_range(0, 3) != 0);
        a  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        h  = ($urandom_range(0, 149) == 0);
        r  = ((c / 40) % 2 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        step(v, rw, a, $urandom, h, r);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
